// File: rtl/spi_dac_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_responder
// Description : SPI mode-2 slave for a multi-channel DAC register bank with
//               input/DAC double buffering and serial readback.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_responder #(
    parameter int NUM_CH     = 16,
    parameter int DATA_W     = 16,
    parameter int FRAME_BITS = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sck,
    input  logic              spi_cs,
    input  logic              spi_mosi,
    output logic              spi_miso,
    input  logic              ldac_n,
    input  logic [3:0]        rd_ch,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_valid,
    output logic [3:0]        frame_cmd,
    output logic [3:0]        frame_addr,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_err
);

    localparam int          PAD_W            = FRAME_BITS - DATA_W;
    localparam logic [1:0]  S_IDLE           = 2'd0;
    localparam logic [1:0]  S_SHIFT          = 2'd1;
    localparam logic [1:0]  S_DECODE         = 2'd2;
    localparam logic [4:0]  c_frame_cnt      = 5'(FRAME_BITS);
    localparam logic [4:0]  c_cnt_max        = 5'd31;
    localparam logic [3:0]  c_cmd_write_in   = 4'h1;
    localparam logic [3:0]  c_cmd_update     = 4'h2;
    localparam logic [3:0]  c_cmd_write_both = 4'h3;
    localparam logic [3:0]  c_cmd_readback   = 4'h9;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic r_sck_meta, r_sck_sync, r_sck_prev;
    logic r_cs_meta,  r_cs_sync,  r_cs_prev;
    logic r_mosi_meta, r_mosi_sync, r_mosi_prev;
    logic [1:0] r_warm;
    logic       r_cs_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sck_meta  <= 1'b1;
            r_sck_sync  <= 1'b1;
            r_sck_prev  <= 1'b1;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_cs_prev   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_mosi_prev <= 1'b0;
        end else begin
            r_sck_meta  <= spi_sck;
            r_sck_sync  <= r_sck_meta;
            r_sck_prev  <= r_sck_sync;
            r_cs_meta   <= spi_cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_prev   <= r_cs_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_mosi_prev <= r_mosi_sync;
        end
    end

    // The synchronizer resets to "deselected", so a chip select already low
    // at reset release would look like a fresh falling edge. A falling edge
    // only counts once a real high level has been seen on the pin.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_warm     <= 2'd0;
            r_cs_ready <= 1'b0;
        end else begin
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end
            if (r_warm == 2'd3 && r_cs_sync) begin
                r_cs_ready <= 1'b1;
            end
        end
    end

    logic w_sck_fall, w_sck_rise, w_cs_fall, w_cs_rise;

    assign w_sck_fall = r_sck_prev & ~r_sck_sync;
    assign w_sck_rise = ~r_sck_prev & r_sck_sync;
    assign w_cs_fall  = r_cs_prev & ~r_cs_sync & r_cs_ready;
    assign w_cs_rise  = ~r_cs_prev & r_cs_sync;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    logic [1:0] r_state, w_next_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_cs_fall) w_next_state = S_SHIFT;
            S_SHIFT:  if (w_cs_rise) w_next_state = S_DECODE;
            S_DECODE: w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    logic [4:0] r_bit_cnt;
    logic       w_start, w_shift_en, w_tx_adv, w_accept, w_reject;

    always_comb begin
        w_start    = 1'b0;
        w_shift_en = 1'b0;
        w_tx_adv   = 1'b0;
        w_accept   = 1'b0;
        w_reject   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_start = w_cs_fall;
            end
            S_SHIFT: begin
                w_shift_en = w_sck_fall;
                w_tx_adv   = w_sck_rise;
            end
            S_DECODE: begin
                w_accept = (r_bit_cnt == c_frame_cnt);
                w_reject = (r_bit_cnt != c_frame_cnt);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Shift/transmit datapath and readback arming
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] r_sr;
    logic [FRAME_BITS-1:0] r_tx;
    logic                  r_rb_armed;
    logic [3:0]            r_rb_addr;
    logic [DATA_W-1:0]     r_input_reg [NUM_CH];
    logic [DATA_W-1:0]     r_dac_reg   [NUM_CH];

    logic [3:0]        w_cmd;
    logic [3:0]        w_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] w_rb_data;

    assign w_cmd     = r_sr[FRAME_BITS-1 -: 4];
    assign w_addr    = r_sr[FRAME_BITS-5 -: 4];
    assign w_data    = r_sr[DATA_W-1:0];
    assign w_rb_data = r_input_reg[r_rb_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sr       <= '0;
            r_bit_cnt  <= 5'd0;
            r_tx       <= '0;
            r_rb_armed <= 1'b0;
            r_rb_addr  <= 4'd0;
        end else begin
            if (w_start) begin
                r_sr      <= '0;
                r_bit_cnt <= 5'd0;
                r_tx      <= r_rb_armed ? {{PAD_W{1'b0}}, w_rb_data} : '0;
            end else if (w_shift_en) begin
                r_sr <= {r_sr[FRAME_BITS-2:0], r_mosi_prev};
                if (r_bit_cnt != c_cnt_max) begin
                    r_bit_cnt <= r_bit_cnt + 5'd1;
                end
            end
            if (w_tx_adv) begin
                r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};
            end
            if (w_accept) begin
                r_rb_armed <= (w_cmd == c_cmd_readback);
                if (w_cmd == c_cmd_readback) begin
                    r_rb_addr <= w_addr;
                end
            end else if (w_reject) begin
                r_rb_armed <= 1'b0;
            end
        end
    end

    assign spi_miso = r_tx[FRAME_BITS-1];

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_input_reg[i] <= '0;
                r_dac_reg[i]   <= '0;
            end
        end else if (w_accept) begin
            case (w_cmd)
                c_cmd_write_in: begin
                    r_input_reg[w_addr] <= w_data;
                    if (!ldac_n) begin
                        r_dac_reg[w_addr] <= w_data;
                    end
                end
                c_cmd_update: begin
                    r_dac_reg[w_addr] <= r_input_reg[w_addr];
                end
                c_cmd_write_both: begin
                    r_input_reg[w_addr] <= w_data;
                    r_dac_reg[w_addr]   <= w_data;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Host-visible outputs
    // ------------------------------------------------------------------
    logic              r_frame_valid, r_frame_err;
    logic [3:0]        r_frame_cmd, r_frame_addr;
    logic [DATA_W-1:0] r_frame_data, r_rd_data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            r_frame_cmd   <= 4'd0;
            r_frame_addr  <= 4'd0;
            r_frame_data  <= '0;
            r_rd_data     <= '0;
        end else begin
            r_frame_valid <= w_accept;
            r_frame_err   <= w_reject;
            if (w_accept) begin
                r_frame_cmd  <= w_cmd;
                r_frame_addr <= w_addr;
                r_frame_data <= w_data;
            end
            r_rd_data <= r_dac_reg[rd_ch];
        end
    end

    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign frame_cmd   = r_frame_cmd;
    assign frame_addr  = r_frame_addr;
    assign frame_data  = r_frame_data;
    assign rd_data     = r_rd_data;

endmodule
`default_nettype wire
